// File: rtl/bcd_digit_sequencer.sv
// Multi-digit packed-BCD adder sequencer.
// Takes two packed BCD operands through a valid/ready handshake and adds them
// one digit per clock, starting with the least significant digit. The decimal
// carry ripples through a register between digits. The packed sum, the final
// carry and a sticky illegal-digit flag are held for the downstream consumer.
module bcd_digit_sequencer #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_a,
  input  logic [4*DIGITS-1:0]   in_b,
  input  logic                  in_c_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_sum,
  output logic                  out_c_out,
  output logic                  out_of_range
);

  localparam int W    = 4 * DIGITS;
  // Keep the index at least one bit wide so DIGITS==1 still elaborates.
  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic            c_out_q, c_out_d;
  logic            oor_q, oor_d;

  // Bit offset of the current digit; two extra bits so 4*idx never overflows.
  logic [IDXW+1:0] bit_off;
  logic [3:0]      digit_a, digit_b;
  logic [4:0]      digit_sum;
  logic [3:0]      digit_res;
  logic            carry_next;
  logic            digit_bad;

  // Single-digit decimal add of the current digit pair plus the rippled carry.
  always_comb begin
    bit_off    = {idx_q, 2'b00};
    digit_a    = a_q[bit_off +: 4];
    digit_b    = b_q[bit_off +: 4];
    digit_sum  = {1'b0, digit_a} + {1'b0, digit_b} + {4'b0000, carry_q};
    if (digit_sum > 5'd9) begin
      // Adding 6 skips the six unused codes; the wrap past 15 is intended.
      digit_res  = digit_sum[3:0] + 4'd6;
      carry_next = 1'b1;
    end else begin
      digit_res  = digit_sum[3:0];
      carry_next = 1'b0;
    end
    digit_bad = (digit_a > 4'd9) || (digit_b > 4'd9);
  end

  // Next-state and datapath updates for the IDLE/RUN/DONE sequence.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    c_out_d = c_out_q;
    oor_d   = oor_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          carry_d = in_c_in;
          idx_d   = '0;
          sum_d   = '0;
          oor_d   = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_d[bit_off +: 4] = digit_res;
        carry_d             = carry_next;
        oor_d               = oor_q | digit_bad;
        if (idx_q == LAST_IDX) begin
          c_out_d = carry_next;
          idx_d   = '0;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      oor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
      oor_q   <= oor_d;
    end
  end

  assign in_ready     = (state_q == S_IDLE);
  assign out_valid    = (state_q == S_DONE);
  assign out_sum      = sum_q;
  assign out_c_out    = c_out_q;
  assign out_of_range = oor_q;

endmodule

// File: tb/tb_bcd_digit_sequencer.sv
// Self-checking bench for bcd_digit_sequencer with DIGITS=4.
// Expected results are queued when an operation is launched and popped when
// the sequencer presents its result.
module tb_bcd_digit_sequencer;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_c_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_c_out;
  logic         out_of_range;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         c_out;
    logic         oor;
  } exp_t;

  exp_t sb_q[$];
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  bcd_digit_sequencer #(.DIGITS(DIGITS)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_c_in      (in_c_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_c_out    (out_c_out),
    .out_of_range (out_of_range)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation, optionally stall the result for bp cycles while
  // offering a different operand pair, then retire it against the scoreboard.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input int bp, input exp_t e);
    int lat;
    exp_t got_e;
    logic [W-1:0] held_sum;
    logic held_c, held_oor;
    check_eq("in_ready_idle", 32'(in_ready), 32'd1);
    sb_q.push_back(e);
    in_a = a; in_b = b; in_c_in = cin; in_valid = 1'b1;
    step();  // accept edge
    in_valid = 1'b0;
    in_a = '0; in_b = '0; in_c_in = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    check_eq("latency", 32'(lat), 32'(DIGITS));
    if (!out_valid) begin
      void'(sb_q.pop_front());
      return;
    end
    held_sum = out_sum; held_c = out_c_out; held_oor = out_of_range;
    for (int i = 0; i < bp; i++) begin
      in_a = 16'h4321; in_b = 16'h1111; in_c_in = 1'b1; in_valid = 1'b1;
      step();
      check_eq("bp_valid", 32'(out_valid), 32'd1);
      check_eq("bp_in_ready", 32'(in_ready), 32'd0);
      check_eq("bp_sum_frozen", 32'(out_sum), 32'(held_sum));
      check_eq("bp_cout_frozen", 32'(out_c_out), 32'(held_c));
      check_eq("bp_oor_frozen", 32'(out_of_range), 32'(held_oor));
    end
    in_valid = 1'b0;
    check_eq("sb_nonempty", 32'(sb_q.size()), 32'd1);
    got_e = sb_q.pop_front();
    check_eq("sum", 32'(out_sum), 32'(got_e.sum));
    check_eq("c_out", 32'(out_c_out), 32'(got_e.c_out));
    check_eq("oor", 32'(out_of_range), 32'(got_e.oor));
    $display("op a=%h b=%h cin=%0d -> sum=%h c_out=%0d oor=%0d (lat %0d)",
             a, b, cin, out_sum, out_c_out, out_of_range, lat);
    out_ready = 1'b1;
    step();  // output handshake edge
    out_ready = 1'b0;
    check_eq("post_in_ready", 32'(in_ready), 32'd1);
    check_eq("post_out_valid", 32'(out_valid), 32'd0);
    check_eq("post_sum_held", 32'(out_sum), 32'(got_e.sum));
    check_eq("post_oor_held", 32'(out_of_range), 32'(got_e.oor));
  endtask

  initial begin
    exp_t e;
    int ra, rb, rv;
    logic rc;
    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_c_in = 1'b0; out_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_sum", 32'(out_sum), 32'd0);
    check_eq("rst_cout", 32'(out_c_out), 32'd0);
    check_eq("rst_oor", 32'(out_of_range), 32'd0);

    // Directed cases.
    e = '{sum: 16'h6912, c_out: 1'b0, oor: 1'b0}; run_op(16'h1234, 16'h5678, 1'b0, 0, e);
    e = '{sum: 16'h0000, c_out: 1'b1, oor: 1'b0}; run_op(16'h9999, 16'h0001, 1'b0, 0, e);
    e = '{sum: 16'h9999, c_out: 1'b1, oor: 1'b0}; run_op(16'h9999, 16'h9999, 1'b1, 0, e);
    // Digit 1 = 0xA: 10 -> (10+6)%16 = 0 with carry, so digit 2 becomes 1.
    e = '{sum: 16'h0100, c_out: 1'b0, oor: 1'b1}; run_op(16'h00A0, 16'h0000, 1'b0, 0, e);
    e = '{sum: 16'h0002, c_out: 1'b0, oor: 1'b0}; run_op(16'h0001, 16'h0001, 1'b0, 0, e);
    // Backpressure with new operands offered during DONE.
    e = '{sum: 16'h5555, c_out: 1'b0, oor: 1'b0}; run_op(16'h1234, 16'h4321, 1'b0, 3, e);

    // Abort in RUN at idx=2.
    in_a = 16'h1111; in_b = 16'h2222; in_c_in = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();  // now processing idx=2
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("abort_in_ready", 32'(in_ready), 32'd1);
    check_eq("abort_out_valid", 32'(out_valid), 32'd0);
    check_eq("abort_sum", 32'(out_sum), 32'd0);
    check_eq("abort_cout", 32'(out_c_out), 32'd0);
    check_eq("abort_oor", 32'(out_of_range), 32'd0);
    for (int i = 0; i < 5; i++) step();
    check_eq("abort_no_result", 32'(out_valid), 32'd0);
    $display("abort during RUN: in_ready=%0d out_valid=%0d", in_ready, out_valid);
    e = '{sum: 16'h0010, c_out: 1'b0, oor: 1'b0}; run_op(16'h0005, 16'h0005, 1'b0, 0, e);

    // Random legal operands checked against integer decimal arithmetic.
    for (int n = 0; n < 8; n++) begin
      ra = int'($urandom_range(0, 9999));
      rb = int'($urandom_range(0, 9999));
      rc = 1'($urandom_range(0, 1));
      rv = ra + rb + int'(rc);
      e.sum   = to_bcd(rv % 10000);
      e.c_out = (rv > 9999);
      e.oor   = 1'b0;
      run_op(to_bcd(ra), to_bcd(rb), rc, n % 3, e);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
